// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the FP32 adder datapath.
//   MANT_W : mantissa width including the hidden bit
//   EXP_W  : exponent width
//   CNT_W  : alignment shift counter width
//   align_state_e : alignment FSM state type (2-bit)
package fp_add_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ALIGN_IDLE  = 2'b00;
    localparam logic [1:0] ALIGN_SHIFT = 2'b01;
    localparam logic [1:0] ALIGN_DONE  = 2'b10;

    typedef enum logic [1:0] {
        AlignIdle  = ALIGN_IDLE,
        AlignShift = ALIGN_SHIFT,
        AlignDone  = ALIGN_DONE
    } align_state_e;

endpackage

// File: rtl/grs_tracker.sv
// Guard/round/sticky tracker for a right-shifting mantissa.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clear_i   : clears G/R/S (new operand captured)
//   shift_i   : one right shift happens this edge
//   bit_in_i  : LSB of the mantissa being shifted out
//   guard_o   : first bit below the LSB
//   round_o   : second bit below the LSB
//   sticky_o  : OR of every bit shifted past round
module grs_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic shift_i,
    input  logic bit_in_i,
    output logic guard_o,
    output logic round_o,
    output logic sticky_o
);

    logic guard_q, round_q, sticky_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (shift_i) begin
            guard_q  <= bit_in_i;
            round_q  <= guard_q;
            sticky_q <= round_q | sticky_q;
        end
    end

    assign guard_o  = guard_q;
    assign round_o  = round_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/mantissa_align_shifter.sv
// Alignment stage of the FP32 adder. Captures the smaller operand's mantissa on
// Load and shifts it right one bit per cycle while shift_enable (from the
// down counter) is high, tracking guard/round/sticky. When shift_enable drops
// the result is held and aligned is raised until the next Load or Reset.
//   Clk          : clock, rising edge
//   Reset        : synchronous active-high reset, highest priority
//   Load         : capture mant_in and start aligning (restarts if already busy)
//   mant_in      : mantissa to align (hidden bit included)
//   shift_enable : high while the shift counter is non-zero
//   mant_out     : aligned mantissa
//   guard/round/sticky : bits shifted out below the LSB
//   shifts_done  : shifts performed since last Load, saturating
//   aligned      : result valid (DONE state)
module mantissa_align_shifter #(
    parameter int unsigned MANT_W = fp_add_pkg::MANT_W,
    parameter int unsigned CNT_W  = fp_add_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              shift_enable,
    output logic [MANT_W-1:0] mant_out,
    output logic              guard,
    output logic              round,
    output logic              sticky,
    output logic [CNT_W-1:0]  shifts_done,
    output logic              aligned
);

    import fp_add_pkg::*;

    align_state_e      state_q, state_d;
    logic [MANT_W-1:0] mant_q;
    logic [CNT_W-1:0]  shifts_q;
    logic              do_load, do_shift;

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_shift = 1'b0;
        if (Load) begin
            do_load = 1'b1;
            state_d = AlignShift;
        end else begin
            unique case (state_q)
                AlignShift: begin
                    if (shift_enable) begin
                        do_shift = 1'b1;
                    end else begin
                        state_d = AlignDone;
                    end
                end
                AlignIdle, AlignDone: ;
                default: state_d = AlignIdle;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= AlignIdle;
            mant_q   <= '0;
            shifts_q <= '0;
        end else begin
            state_q <= state_d;
            if (do_load) begin
                mant_q   <= mant_in;
                shifts_q <= '0;
            end else if (do_shift) begin
                mant_q <= {1'b0, mant_q[MANT_W-1:1]};
                if (shifts_q != '1) begin
                    shifts_q <= shifts_q + 1'b1;
                end
            end
        end
    end

    grs_tracker u_grs_tracker (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .clear_i  (do_load),
        .shift_i  (do_shift),
        .bit_in_i (mant_q[0]),
        .guard_o  (guard),
        .round_o  (round),
        .sticky_o (sticky)
    );

    assign mant_out    = mant_q;
    assign shifts_done = shifts_q;
    // Decode of registered state only; no input-to-output path.
    assign aligned     = (state_q == AlignDone);

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// Bench for mantissa_align_shifter with a behavioural 5-bit down counter
// driving shift_enable (high while the count is non-zero).
module tb_mantissa_align_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [23:0] mant_in;
    logic        shift_enable;
    logic [23:0] mant_out;
    logic        guard, round, sticky;
    logic [4:0]  shifts_done;
    logic        aligned;

    // Down counter model
    logic [4:0]  cnt = 5'd0;
    logic        ctr_load = 1'b0;
    logic [4:0]  ctr_val = 5'd0;
    logic        force_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ctr_load) cnt <= ctr_val;
        else if (cnt != 5'd0) cnt <= cnt - 5'd1;
    end

    assign shift_enable = (cnt != 5'd0) || force_en;

    mantissa_align_shifter dut (
        .Clk          (clk),
        .Reset        (reset),
        .Load         (load),
        .mant_in      (mant_in),
        .shift_enable (shift_enable),
        .mant_out     (mant_out),
        .guard        (guard),
        .round        (round),
        .sticky       (sticky),
        .shifts_done  (shifts_done),
        .aligned      (aligned)
    );

    typedef struct {
        logic [23:0] mant;
        logic [4:0]  count;
        logic [23:0] exp_mant;
        logic [2:0]  exp_grs;
        logic [4:0]  exp_sd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [23:0] m, input logic [2:0] grs,
                                input logic [4:0] sd);
        check({tag, " mant_out"}, {8'd0, mant_out}, {8'd0, m});
        check({tag, " grs"}, {29'd0, guard, round, sticky}, {29'd0, grs});
        check({tag, " shifts_done"}, {27'd0, shifts_done}, {27'd0, sd});
        check({tag, " aligned"}, {31'd0, aligned}, 32'd1);
    endtask

    // Load at edge E0; returns at the negedge just after E0.
    task automatic start(input logic [23:0] m, input logic [4:0] n);
        @(negedge clk);
        load = 1'b1; mant_in = m; ctr_load = 1'b1; ctr_val = n;
        @(negedge clk);
        load = 1'b0; ctr_load = 1'b0;
    endtask

    // Counts edges after E0 until aligned, bounded.
    task automatic wait_aligned(output int edges);
        edges = 0;
        while (!aligned && edges < 64) begin
            @(negedge clk);
            edges++;
        end
    endtask

    int edges;

    initial begin
        vecs[0] = '{24'h800000, 5'd7,  24'h010000, 3'b000, 5'd7};
        vecs[1] = '{24'hFFFFFF, 5'd3,  24'h1FFFFF, 3'b111, 5'd3};
        vecs[2] = '{24'h800001, 5'd31, 24'h000000, 3'b001, 5'd31};
        vecs[3] = '{24'hABCDEF, 5'd0,  24'hABCDEF, 3'b000, 5'd0};
        vecs[4] = '{24'h000000, 5'd20, 24'h000000, 3'b000, 5'd20};
        vecs[5] = '{24'h000001, 5'd1,  24'h000000, 3'b100, 5'd1};
        vecs[6] = '{24'h000003, 5'd2,  24'h000000, 3'b110, 5'd2};

        reset = 1'b1; load = 1'b0; mant_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset mant_out", {8'd0, mant_out}, 32'd0);
        check("reset grs", {29'd0, guard, round, sticky}, 32'd0);
        check("reset shifts_done", {27'd0, shifts_done}, 32'd0);
        check("reset aligned", {31'd0, aligned}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            start(vecs[i].mant, vecs[i].count);
            check($sformatf("v%0d aligned low after load", i), {31'd0, aligned}, 32'd0);
            wait_aligned(edges);
            check($sformatf("v%0d latency", i), edges, vecs[i].count + 1);
            check_result($sformatf("v%0d", i), vecs[i].exp_mant, vecs[i].exp_grs, vecs[i].exp_sd);
        end

        // DONE ignores shift_enable.
        force_en = 1'b1;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        check_result("done hold", 24'h000000, 3'b110, 5'd2);

        // Reset aborts a shift in progress; IDLE ignores shift_enable.
        start(24'h800000, 5'd10);
        repeat (4) @(negedge clk);
        check("abort pre mant_out", {8'd0, mant_out}, 32'h080000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort shift_enable high", {31'd0, shift_enable}, 32'd1);
        check("abort mant_out", {8'd0, mant_out}, 32'd0);
        check("abort grs", {29'd0, guard, round, sticky}, 32'd0);
        check("abort shifts_done", {27'd0, shifts_done}, 32'd0);
        check("abort aligned", {31'd0, aligned}, 32'd0);
        start(24'hC00000, 5'd2);
        wait_aligned(edges);
        check("restart latency", edges, 3);
        check_result("restart", 24'h300000, 3'b000, 5'd2);

        // Load again mid-SHIFT discards the old operand.
        start(24'hFFFFFF, 5'd9);
        repeat (2) @(negedge clk);
        start(24'h000003, 5'd5);
        wait_aligned(edges);
        check("reload latency", edges, 6);
        check_result("reload", 24'h000000, 3'b001, 5'd5);

        // shifts_done saturates when shift_enable stays high past 31 shifts.
        @(negedge clk);
        load = 1'b1; mant_in = 24'h800001; ctr_load = 1'b1; ctr_val = 5'd0; force_en = 1'b1;
        @(negedge clk);
        load = 1'b0; ctr_load = 1'b0;
        repeat (39) @(negedge clk);
        force_en = 1'b0;
        wait_aligned(edges);
        check("saturate latency", edges, 1);
        check_result("saturate", 24'h000000, 3'b001, 5'd31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
